// File: rtl/reg_file_sb.sv
// Register file with a pending-bit scoreboard for multi-cycle results.
// Two combinational read ports with write/retire bypass, one ALU write port,
// an issue port that reserves a destination, and a retire port that returns
// the reserved result. Protocol misuse latches errSticky until reset.
module reg_file_sb #(
    parameter int unsigned REGISTER_WIDTH      = 8,
    parameter int unsigned NUMBER_OF_REGISTERS = 8,
    parameter int unsigned ADDR_WIDTH          = 3,
    parameter int unsigned MAX_PENDING         = 2
) (
    input  logic                      clock,
    input  logic                      isReset,
    input  logic [ADDR_WIDTH-1:0]     rdAddr1,
    input  logic [ADDR_WIDTH-1:0]     rdAddr2,
    output logic [REGISTER_WIDTH-1:0] rdData1,
    output logic [REGISTER_WIDTH-1:0] rdData2,
    output logic                      rdBusy1,
    output logic                      rdBusy2,
    output logic                      stall,
    input  logic                      wrEnable,
    input  logic [ADDR_WIDTH-1:0]     wrAddr,
    input  logic [REGISTER_WIDTH-1:0] wrData,
    input  logic                      issueValid,
    input  logic [ADDR_WIDTH-1:0]     issueAddr,
    output logic                      issueReady,
    input  logic                      retireValid,
    input  logic [ADDR_WIDTH-1:0]     retireAddr,
    input  logic [REGISTER_WIDTH-1:0] retireData,
    output logic [ADDR_WIDTH:0]       pendingCount,
    output logic                      errSticky
);

    localparam logic [ADDR_WIDTH:0] MAX_COUNT = (ADDR_WIDTH + 1)'(MAX_PENDING);

    logic [REGISTER_WIDTH-1:0]      regs_q [NUMBER_OF_REGISTERS];
    logic [NUMBER_OF_REGISTERS-1:0] pending_q, pending_d;
    logic [ADDR_WIDTH:0]            count_q, count_d;
    logic                           err_q, err_d;

    logic issue_fire;   // accepted issue to a non-zero address
    logic retire_fire;  // retire that lands in the register file
    logic write_fire;   // ALU write that lands in the register file
    logic retire_err;
    logic write_err;

    // Issue handshake looks at registered state only.
    always_comb begin
        issueReady = ~pending_q[issueAddr] & (count_q < MAX_COUNT);
    end

    // Decide which of this cycle's requests take effect; all gated off while in reset.
    always_comb begin
        issue_fire  = isReset & issueValid & issueReady & (issueAddr != '0);
        // A retire matching a same-cycle accepted issue is kept: data lands, bit stays set.
        retire_fire = isReset & retireValid & (retireAddr != '0) &
                      (pending_q[retireAddr] | (issue_fire & (issueAddr == retireAddr)));
        retire_err  = isReset & retireValid & (retireAddr != '0) & ~retire_fire;
        write_err   = isReset & wrEnable & (wrAddr != '0) & pending_q[wrAddr];
        write_fire  = isReset & wrEnable & (wrAddr != '0) & ~pending_q[wrAddr] &
                      ~(retire_fire & (retireAddr == wrAddr));
    end

    // Read ports: register 0 is hardwired zero, retire bypass beats write bypass.
    always_comb begin
        rdData1 = regs_q[rdAddr1];
        if (retire_fire && (retireAddr == rdAddr1)) begin
            rdData1 = retireData;
        end else if (write_fire && (wrAddr == rdAddr1)) begin
            rdData1 = wrData;
        end
        if (rdAddr1 == '0) begin
            rdData1 = '0;
        end
        rdData2 = regs_q[rdAddr2];
        if (retire_fire && (retireAddr == rdAddr2)) begin
            rdData2 = retireData;
        end else if (write_fire && (wrAddr == rdAddr2)) begin
            rdData2 = wrData;
        end
        if (rdAddr2 == '0) begin
            rdData2 = '0;
        end
    end

    // Busy flags: a same-cycle retire to the read address releases the stall.
    always_comb begin
        rdBusy1 = pending_q[rdAddr1] & ~(retireValid & (retireAddr == rdAddr1));
        rdBusy2 = pending_q[rdAddr2] & ~(retireValid & (retireAddr == rdAddr2));
        stall   = rdBusy1 | rdBusy2;
    end

    // Scoreboard next state: retire clears, issue sets afterwards so issue wins.
    always_comb begin
        pending_d = pending_q;
        if (retire_fire) begin
            pending_d[retireAddr] = 1'b0;
        end
        if (issue_fire) begin
            pending_d[issueAddr] = 1'b1;
        end
        pending_d[0] = 1'b0;

        count_d = count_q;
        case ({issue_fire, retire_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = (count_q != '0) ? count_q - 1'b1 : count_q;
            default: count_d = count_q;
        endcase

        err_d = err_q | retire_err | write_err;
    end

    // Scoreboard state registers.
    always_ff @(posedge clock or negedge isReset) begin
        if (!isReset) begin
            pending_q <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    // Register storage; write_fire never shares an address with retire_fire.
    always_ff @(posedge clock or negedge isReset) begin
        if (!isReset) begin
            for (int unsigned i = 0; i < NUMBER_OF_REGISTERS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (write_fire) begin
                regs_q[wrAddr] <= wrData;
            end
            if (retire_fire) begin
                regs_q[retireAddr] <= retireData;
            end
        end
    end

    assign pendingCount = count_q;
    assign errSticky    = err_q;

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter REGISTER_WIDTH, default 8, meaning data bits per register.
REQ-002 SHALL have parameter NUMBER_OF_REGISTERS, default 8, meaning register count (power of two, >=4).
REQ-003 SHALL have parameter ADDR_WIDTH, default 3, meaning log2(NUMBER_OF_REGISTERS).
REQ-004 SHALL have parameter MAX_PENDING, default 2, meaning maximum simultaneously reserved registers (1..NUMBER_OF_REGISTERS-1).
REQ-005 SHALL have port clock  input  1  meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port isReset  input  1  meaning asynchronous, active-low reset (0 = reset).
REQ-007 SHALL have ports rdAddr1, rdAddr2  input  ADDR_WIDTH  meaning operand read addresses.
REQ-008 SHALL have ports rdData1, rdData2  output  REGISTER_WIDTH  meaning combinational read data.
REQ-009 SHALL have ports rdBusy1, rdBusy2  output  1  meaning the addressed register awaits a multi-cycle result.
REQ-010 SHALL have port stall  output  1  meaning rdBusy1 OR rdBusy2.
REQ-011 SHALL have ports wrEnable  input  1, wrAddr  input  ADDR_WIDTH, wrData  input  REGISTER_WIDTH  meaning single-cycle (ALU) write.
REQ-012 SHALL have ports issueValid  input  1, issueAddr  input  ADDR_WIDTH, issueReady  output  1  meaning reservation of a destination for a multi-cycle result.
REQ-013 SHALL have ports retireValid  input  1, retireAddr  input  ADDR_WIDTH, retireData  input  REGISTER_WIDTH  meaning return of a multi-cycle result.
REQ-014 SHALL have port pendingCount  output  ADDR_WIDTH+1  meaning number of reserved registers.
REQ-015 SHALL have port errSticky  output  1  meaning a protocol violation has occurred since reset.

Function
REQ-016 SHALL read register 0 as zero, ignore all writes/retires to it, and never mark it pending; issue to address 0 SHALL be accepted as a no-op.
REQ-017 SHALL commit wrEnable writes on the rising edge, visible on reads the next cycle.
REQ-018 SHALL bypass: a read of an address being written or retired in the same cycle returns that cycle's wrData/retireData combinationally.
REQ-019 SHALL keep one pending bit per register; an issue handshake (issueValid AND issueReady) sets the bit at the edge.
REQ-020 SHALL drive issueReady = NOT pending[issueAddr] AND pendingCount < MAX_PENDING, from registered state only (no same-cycle retire credit).
REQ-021 SHALL, on retireValid to a pending register, write retireData and clear its pending bit at the edge.
REQ-022 SHALL drive rdBusyN = pending[rdAddrN] AND NOT (retireValid AND retireAddr == rdAddrN), so a same-cycle retire releases the stall.
REQ-023 SHALL, on retire to a non-pending register, discard the data and set errSticky.
REQ-024 SHALL, on wrEnable to a pending register, discard the write and set errSticky.
REQ-025 SHALL, when wrEnable and retireValid target the same non-zero pending address, apply the retire and discard the write (REQ-024 sets errSticky).
REQ-026 SHALL, when an accepted issue and a retire hit the same address in one cycle, write retireData and leave the bit set (issue wins).
REQ-027 SHALL update pendingCount as +1 per accepted issue (non-zero address), -1 per valid retire, net in one cycle; it SHALL never exceed MAX_PENDING or underflow.
REQ-028 SHALL keep errSticky set until reset.

Reset
REQ-029 SHALL, while isReset = 0, asynchronously clear all registers to 0, all pending bits, pendingCount and errSticky; rdBusy1/2 and stall SHALL read 0 and issueReady 1.
REQ-030 SHALL discard in-flight reservations on reset; a retire arriving after reset release SHALL set errSticky.
REQ-031 SHALL ignore wrEnable/issueValid/retireValid while isReset = 0 and resume on the first rising edge after release.

Verification
REQ-032 SHALL cover: write r3=0x5A, read r3 same cycle and next cycle -> 0x5A both (bypass then stored); write r0=0xFF -> r0 reads 0.
REQ-033 SHALL cover: issue r2, then rdAddr1=2 -> rdBusy1=1, stall=1 until retire r2=0x11; retire cycle rdBusy1=0, rdData1=0x11.
REQ-034 SHALL cover: issue r1, r4 (MAX_PENDING=2) -> pendingCount=2, issueReady=0 for r5; retire r1 -> next cycle issueReady=1.
REQ-035 SHALL cover: wrEnable to pending r4 with 0x77 -> r4 unchanged, errSticky=1; retire to idle r6 -> r6 unchanged.
REQ-036 SHALL cover: issue and retire r5 same cycle -> r5 = retireData, pending stays 1, pendingCount unchanged.
REQ-037 SHALL cover: reset asserted mid-operation with 2 pending -> all outputs reset values immediately; later retire sets errSticky.
